// File: rtl/img_stream_pkg.sv
// Shared state encoding and default frame geometry for the image stream source.
package img_stream_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_BLANK = 2'd2,
        ST_FLUSH = 2'd3
    } state_e;

    localparam int ROWS_DEF     = 9;
    localparam int COLS_DEF     = 9;
    localparam int BLANK_DEF    = 2;
    localparam int FLUSH_CYCLES = 2;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/image_stream_source_raster_counter.sv
// Row/column raster counter for the image stream source; both counters wrap
// together on the last pixel so the next frame starts at row 0, col 0.
module raster_counter
    import img_stream_pkg::*;
#(
    parameter int ROWS  = ROWS_DEF,
    parameter int COLS  = COLS_DEF,
    parameter int ROW_W = $clog2(ROWS),
    parameter int COL_W = $clog2(COLS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    output logic [ROW_W-1:0] row_o,
    output logic [COL_W-1:0] col_o,
    output logic             col_last_o,
    output logic             row_last_o
);

    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] col_q, col_d;

    assign col_last_o = (col_q == COL_W'(COLS - 1));
    assign row_last_o = (row_q == ROW_W'(ROWS - 1));
    assign row_o      = row_q;
    assign col_o      = col_q;

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (en_i) begin
            if (col_last_o) begin
                col_d = '0;
                row_d = row_last_o ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

endmodule

// File: rtl/image_stream_source.sv
// Streams one raster-ordered frame from pixel memory to the grayscale output.
// Inter-row blanking is built only when IMAGE_STREAM_SOURCE_BLANK_EN is defined.
//
// state    | meaning
// ST_IDLE  | waiting for start_i
// ST_READ  | one memory read per cycle, raster order
// ST_BLANK | idle gap of BLANK cycles between rows
// ST_FLUSH | two cycles for the read/output pipeline to drain
module image_stream_source
    import img_stream_pkg::*;
#(
    parameter int ROWS   = ROWS_DEF,
    parameter int COLS   = COLS_DEF,
    parameter int BLANK  = BLANK_DEF,
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    output logic              mem_rd_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [7:0]        mem_data_i,
    output logic [7:0]        grayscale_o,
    output logic              done_o,
    output logic              busy_o,
    output logic              frame_done_o
);

    localparam int ROW_W = $clog2(ROWS);
    localparam int COL_W = $clog2(COLS);
    // One down-counter serves both the flush wait and, when built, the blanking gap.
    localparam int WAIT_W = $clog2(max_int(BLANK, FLUSH_CYCLES));

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [ROW_W-1:0]  row;
    logic [COL_W-1:0]  col;
    logic              col_last, row_last;
    logic              cnt_en, last_px, mem_rd;
    logic              rd_d1_q, last_d1_q, done_q, fdone_q;
    logic [7:0]        gray_q;

    raster_counter #(
        .ROWS  (ROWS),
        .COLS  (COLS),
        .ROW_W (ROW_W),
        .COL_W (COL_W)
    ) u_raster (
        .clk        (clk),
        .rst        (rst),
        .en_i       (cnt_en),
        .row_o      (row),
        .col_o      (col),
        .col_last_o (col_last),
        .row_last_o (row_last)
    );

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        cnt_en  = 1'b0;
        last_px = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) state_d = ST_READ;
            end
            ST_READ: begin
                cnt_en = 1'b1;
                if (col_last) begin
                    if (row_last) begin
                        last_px = 1'b1;
                        state_d = ST_FLUSH;
                        wait_d  = WAIT_W'(FLUSH_CYCLES - 1);
                    end
`ifdef IMAGE_STREAM_SOURCE_BLANK_EN
                    else begin
                        state_d = ST_BLANK;
                        wait_d  = WAIT_W'(BLANK - 1);
                    end
`endif
                end
            end
`ifdef IMAGE_STREAM_SOURCE_BLANK_EN
            ST_BLANK: begin
                if (wait_q == '0) state_d = ST_READ;
                else              wait_d  = wait_q - 1'b1;
            end
`endif
            ST_FLUSH: begin
                if (wait_q == '0) state_d = ST_IDLE;
                else              wait_d  = wait_q - 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign mem_rd = (state_q == ST_READ);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            wait_q    <= '0;
            rd_d1_q   <= 1'b0;
            last_d1_q <= 1'b0;
            done_q    <= 1'b0;
            fdone_q   <= 1'b0;
            gray_q    <= 8'h00;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            rd_d1_q   <= mem_rd;
            last_d1_q <= last_px;
            done_q    <= rd_d1_q;
            fdone_q   <= last_d1_q;
            // Memory data is only meaningful the cycle after a read; zero otherwise.
            gray_q    <= rd_d1_q ? mem_data_i : 8'h00;
        end
    end

    assign mem_rd_o     = mem_rd;
    assign mem_addr_o   = mem_rd ? (ADDR_W'(row) * ADDR_W'(COLS) + ADDR_W'(col)) : '0;
    assign grayscale_o  = gray_q;
    assign done_o       = done_q;
    assign frame_done_o = fdone_q;
    assign busy_o       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_image_stream_source.sv
// Bench for image_stream_source: a 9x9 instance against a timing/data model,
// and a 2x3 instance against a hand-written cycle table.
module tb_image_stream_source;

    localparam int ROWS_A = 9, COLS_A = 9, BLANK_A = 2, NA = ROWS_A * COLS_A;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, start_a, rd_a, done_a, busy_a, fdone_a;
    logic [6:0] addr_a;
    logic [7:0] data_a, gray_a;
    logic       rst_b, start_b, rd_b, done_b, busy_b, fdone_b;
    logic [2:0] addr_b;
    logic [7:0] data_b, gray_b;

    logic [7:0] mem_a [128];
    logic [7:0] mem_b [8];

    int n_checks = 0;
    int n_err    = 0;

    image_stream_source #(.ROWS(ROWS_A), .COLS(COLS_A), .BLANK(BLANK_A), .ADDR_W(7)) u_dut_a (
        .clk(clk), .rst(rst_a), .start_i(start_a), .mem_rd_o(rd_a), .mem_addr_o(addr_a),
        .mem_data_i(data_a), .grayscale_o(gray_a), .done_o(done_a), .busy_o(busy_a),
        .frame_done_o(fdone_a)
    );

    image_stream_source #(.ROWS(2), .COLS(3), .BLANK(2), .ADDR_W(3)) u_dut_b (
        .clk(clk), .rst(rst_b), .start_i(start_b), .mem_rd_o(rd_b), .mem_addr_o(addr_b),
        .mem_data_i(data_b), .grayscale_o(gray_b), .done_o(done_b), .busy_o(busy_b),
        .frame_done_o(fdone_b)
    );

    // Synchronous-read memories; junk on the data bus when not reading.
    always @(posedge clk) begin
        data_a <= rd_a ? mem_a[addr_a] : 8'($urandom);
        data_b <= rd_b ? mem_b[addr_b] : 8'($urandom);
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Cycle offset of pixel k from the first read of the frame.
    function automatic int off_a(input int k);
`ifdef IMAGE_STREAM_SOURCE_BLANK_EN
        return k + (k / COLS_A) * BLANK_A;
`else
        return k;
`endif
    endfunction

    function automatic int find_k(input int d);
        for (int k = 0; k < NA; k++)
            if (off_a(k) == d) return k;
        return -1;
    endfunction

    // rel = cycles since the cycle in which start_a was high.
    task automatic check_a(input int rel, input int last);
        int kd, kr;
        kd = find_k(rel - 3);
        kr = find_k(rel - 1);
        chk("a_done",       int'(done_a),  (kd >= 0) ? 1 : 0);
        chk("a_gray",       int'(gray_a),  (kd >= 0) ? int'(mem_a[kd]) : 0);
        chk("a_frame_done", int'(fdone_a), (kd == NA - 1) ? 1 : 0);
        chk("a_busy",       int'(busy_a),  (rel >= 1 && rel <= last) ? 1 : 0);
        chk("a_rd",         int'(rd_a),    (kr >= 0) ? 1 : 0);
        chk("a_addr",       int'(addr_a),  (kr >= 0) ? kr : 0);
    endtask

    // Called at a negedge; returns at the negedge after its last checked cycle,
    // or right after driving reset when abort_px >= 0.
    task automatic run_a(input bit hold, input int tail, input int abort_px);
        int last;
        last = 3 + off_a(NA - 1);
        start_a = 1'b1;
        for (int rel = 0; rel <= last + tail; rel++) begin
            if (rel == 1) start_a = hold;
            if (rel == last) start_a = 1'b0;
            check_a(rel, last);
            if (abort_px >= 0 && rel == 3 + off_a(abort_px)) begin
                rst_a = 1'b0;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic fill_a_random();
        for (int i = 0; i < 128; i++) mem_a[i] = 8'($urandom);
    endtask

    typedef struct {
        bit start;
        bit rd;
        int addr;
        bit done;
        int gray;
        bit fdone;
        bit busy;
    } vec_t;

    function automatic vec_t mk(bit s, bit r, int a, bit d, int g, bit f, bit b);
        vec_t v;
        v.start = s; v.rd = r; v.addr = a; v.done = d; v.gray = g; v.fdone = f; v.busy = b;
        return v;
    endfunction

    vec_t vec_b[$];

    initial begin
        // 2x3 frame, memory holds 0xA0+addr: start, rd, addr, done, gray, fdone, busy
`ifdef IMAGE_STREAM_SOURCE_BLANK_EN
        vec_b.push_back(mk(1, 0, 0, 0, 0,     0, 0));
        vec_b.push_back(mk(0, 1, 0, 0, 0,     0, 1));
        vec_b.push_back(mk(0, 1, 1, 0, 0,     0, 1));
        vec_b.push_back(mk(0, 1, 2, 1, 'hA0,  0, 1));
        vec_b.push_back(mk(0, 0, 0, 1, 'hA1,  0, 1));
        vec_b.push_back(mk(0, 0, 0, 1, 'hA2,  0, 1));
        vec_b.push_back(mk(0, 1, 3, 0, 0,     0, 1));
        vec_b.push_back(mk(0, 1, 4, 0, 0,     0, 1));
        vec_b.push_back(mk(0, 1, 5, 1, 'hA3,  0, 1));
        vec_b.push_back(mk(0, 0, 0, 1, 'hA4,  0, 1));
        vec_b.push_back(mk(0, 0, 0, 1, 'hA5,  1, 1));
        vec_b.push_back(mk(0, 0, 0, 0, 0,     0, 0));
        vec_b.push_back(mk(0, 0, 0, 0, 0,     0, 0));
`else
        vec_b.push_back(mk(1, 0, 0, 0, 0,     0, 0));
        vec_b.push_back(mk(0, 1, 0, 0, 0,     0, 1));
        vec_b.push_back(mk(0, 1, 1, 0, 0,     0, 1));
        vec_b.push_back(mk(0, 1, 2, 1, 'hA0,  0, 1));
        vec_b.push_back(mk(0, 1, 3, 1, 'hA1,  0, 1));
        vec_b.push_back(mk(0, 1, 4, 1, 'hA2,  0, 1));
        vec_b.push_back(mk(0, 1, 5, 1, 'hA3,  0, 1));
        vec_b.push_back(mk(0, 0, 0, 1, 'hA4,  0, 1));
        vec_b.push_back(mk(0, 0, 0, 1, 'hA5,  1, 1));
        vec_b.push_back(mk(0, 0, 0, 0, 0,     0, 0));
        vec_b.push_back(mk(0, 0, 0, 0, 0,     0, 0));
`endif

        rst_a = 1'b0; rst_b = 1'b0; start_a = 1'b0; start_b = 1'b0;
        for (int i = 0; i < 128; i++) mem_a[i] = 8'(i);
        for (int i = 0; i < 8; i++)   mem_b[i] = 8'('hA0 + i);
        repeat (3) @(negedge clk);

        chk("rst_a_done",  int'(done_a),  0);
        chk("rst_a_gray",  int'(gray_a),  0);
        chk("rst_a_fdone", int'(fdone_a), 0);
        chk("rst_a_busy",  int'(busy_a),  0);
        chk("rst_a_rd",    int'(rd_a),    0);
        chk("rst_b_busy",  int'(busy_b),  0);
        chk("rst_b_done",  int'(done_b),  0);
        rst_a = 1'b1; rst_b = 1'b1;
        @(negedge clk);

        // Data = address, single start pulse.
        run_a(1'b0, 3, -1);

        // Start held high for the whole frame: exactly one frame.
        fill_a_random();
        run_a(1'b1, 4, -1);

        // Back-to-back: second start in the first idle cycle after flush.
        fill_a_random();
        run_a(1'b0, 0, -1);
        run_a(1'b0, 3, -1);

        // Reset while pixel 40 is on the output.
        run_a(1'b0, 0, 40);
        @(negedge clk);
        chk("abort_done",  int'(done_a),  0);
        chk("abort_gray",  int'(gray_a),  0);
        chk("abort_fdone", int'(fdone_a), 0);
        chk("abort_busy",  int'(busy_a),  0);
        chk("abort_rd",    int'(rd_a),    0);
        chk("abort_addr",  int'(addr_a),  0);
        rst_a = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("post_abort_done",  int'(done_a),  0);
            chk("post_abort_fdone", int'(fdone_a), 0);
            chk("post_abort_busy",  int'(busy_a),  0);
        end
        @(negedge clk);
        run_a(1'b0, 2, -1);

        // Random memory contents, random idle gaps, random start holding.
        for (int f = 0; f < 3; f++) begin
            int gap;
            fill_a_random();
            gap = int'($urandom_range(0, 5));
            for (int g = 0; g < gap; g++) begin
                chk("idle_done", int'(done_a), 0);
                chk("idle_busy", int'(busy_a), 0);
                @(negedge clk);
            end
            run_a(1'($urandom_range(0, 1)), 2, -1);
        end

        // 2x3 instance against the cycle table.
        for (int i = 0; i < vec_b.size(); i++) begin
            start_b = vec_b[i].start;
            chk("b_rd",    int'(rd_b),    int'(vec_b[i].rd));
            chk("b_addr",  int'(addr_b),  vec_b[i].addr);
            chk("b_done",  int'(done_b),  int'(vec_b[i].done));
            chk("b_gray",  int'(gray_b),  vec_b[i].gray);
            chk("b_fdone", int'(fdone_b), int'(vec_b[i].fdone));
            chk("b_busy",  int'(busy_b),  int'(vec_b[i].busy));
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1, "watchdog");
    end

endmodule
